// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Iterative unsigned multiply / divide engine for the two long-latency ALU
//   codes (4'b1111 = mult, 4'b1110 = div). Takes WIDTH iterations per
//   operation and reports results on LO (ALUresult) and HI.
//
// Ports
//   clk                 system clock, rising edge
//   reset               synchronous, active-high
//   start               request strobe, only honoured in IDLE
//   Data_1              multiplicand / dividend
//   Data_2              multiplier / divisor
//   ALU_control_signal  1111 = mult, 1110 = div, other codes ignored
//   busy                high while iterating
//   done                one-cycle pulse, results valid
//   ALUresult           product low half, or quotient
//   HI                  product high half, or remainder
//   Zero                registered (ALUresult == 0)
//   div_by_zero         registered, last completed op was div by 0
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] Data_1,
  input  logic [WIDTH-1:0] Data_2,
  input  logic [3:0]       ALU_control_signal,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALUresult,
  output logic [WIDTH-1:0] HI,
  output logic             Zero,
  output logic             div_by_zero
);

  localparam logic [3:0]  OP_MULT = 4'b1111;
  localparam logic [3:0]  OP_DIV  = 4'b1110;
  localparam int unsigned CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic             op_div;
  logic [WIDTH-1:0] addend;
  logic [2*WIDTH:0] acc;
  logic [2*WIDTH:0] acc_step;
  logic [WIDTH:0]   part;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             accept;
  logic             last_iter;

  // Control
  always_comb begin
    accept    = (state == IDLE) && start &&
                ((ALU_control_signal == OP_MULT) || (ALU_control_signal == OP_DIV));
    last_iter = (state == RUN) && (count == CW'(WIDTH - 1));
    busy      = (state == RUN);
    done      = (state == DONE);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // One iteration of the shared working register.
  // acc[2W:W] is the running upper part (product high / partial remainder),
  // acc[W-1:0] holds the multiplier bits being consumed or the dividend bits
  // being shifted out while quotient bits shift in from the bottom.
  // Both algorithms finish with {HI, LO} in acc[2W-1:0], so the write-back
  // is common to mult and div.
  always_comb begin
    part     = acc[2*WIDTH:WIDTH];
    sum      = part + (acc[0] ? {1'b0, addend} : '0);
    shifted  = {part[WIDTH-1:0], acc[WIDTH-1]};
    diff     = shifted - {1'b0, addend};
    acc_step = '0;
    if (op_div) begin
      // diff[WIDTH] set means the trial subtraction went negative: restore.
      acc_step = {(diff[WIDTH] ? shifted : diff), acc[WIDTH-2:0], ~diff[WIDTH]};
    end else begin
      acc_step = {1'b0, sum, acc[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= '0;
      op_div      <= 1'b0;
      addend      <= '0;
      acc         <= '0;
      ALUresult   <= '0;
      HI          <= '0;
      Zero        <= 1'b1;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      count  <= '0;
      op_div <= (ALU_control_signal == OP_DIV);
      if (ALU_control_signal == OP_DIV) begin
        addend <= Data_2;
        acc    <= {{(WIDTH + 1){1'b0}}, Data_1};
      end else begin
        addend <= Data_1;
        acc    <= {{(WIDTH + 1){1'b0}}, Data_2};
      end
    end else if (state == RUN) begin
      acc   <= acc_step;
      count <= count + CW'(1);
      if (last_iter) begin
        ALUresult   <= acc_step[WIDTH-1:0];
        HI          <= acc_step[2*WIDTH-1:WIDTH];
        Zero        <= (acc_step[WIDTH-1:0] == '0);
        div_by_zero <= op_div && (addend == '0);
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
//   Directed bench for mult_div_unit. A cycle-level reference model
//   (arithmetic result plus completion time) is compared with every DUT
//   output on each falling edge; directed cases add literal expectations.
module tb_mult_div_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] d1, d2;
  logic [3:0]   ctl;
  logic         busy, done, zero, dbz;
  logic [W-1:0] lo, hi;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .Data_1            (d1),
    .Data_2            (d2),
    .ALU_control_signal(ctl),
    .busy              (busy),
    .done              (done),
    .ALUresult         (lo),
    .HI                (hi),
    .Zero              (zero),
    .div_by_zero       (dbz)
  );

  // ---------------- reference model ----------------
  // returns {div_by_zero, HI, LO}
  function automatic logic [2*W:0] golden(input bit is_div, input logic [W-1:0] a, b);
    logic [2*W-1:0] p;
    if (is_div) begin
      if (b == '0) return {1'b1, a, {W{1'b1}}};
      return {1'b0, a % b, a / b};
    end
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return {1'b0, p};
  endfunction

  int           cyc = 0;
  bit           m_valid = 1'b0;
  bit           m_pend = 1'b0;
  bit           m_done = 1'b0;
  int           m_fin = 0;
  logic [2*W:0] m_res = '0;
  logic [W-1:0] m_lo = '0, m_hi = '0;
  bit           m_zero = 1'b1, m_dbz = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      m_valid <= 1'b1;
      m_pend  <= 1'b0;
      m_done  <= 1'b0;
      m_lo    <= '0;
      m_hi    <= '0;
      m_zero  <= 1'b1;
      m_dbz   <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_pend && cyc == m_fin) begin
        m_pend <= 1'b0;
        m_done <= 1'b1;
        m_lo   <= m_res[W-1:0];
        m_hi   <= m_res[2*W-1:W];
        m_zero <= (m_res[W-1:0] == '0);
        m_dbz  <= m_res[2*W];
      end else if (!m_pend && !m_done && start && (ctl == 4'hF || ctl == 4'hE)) begin
        m_pend <= 1'b1;
        m_fin  <= cyc + int'(W);
        m_res  <= golden(ctl == 4'hE, d1, d2);
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle_check();
    logic [2*W+3:0] got, exp;
    if (m_valid) begin
      got = {busy, done, zero, dbz, hi, lo};
      exp = {m_pend, m_done, m_zero, m_dbz, m_hi, m_lo};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL model {busy,done,Zero,dbz,HI,LO}: got %0h expected %0h (t=%0t)",
                 got, exp, $time);
      end
      if (busy && done) begin
        n_fail++;
        $display("FAIL busy_and_done: got 1 expected 0 (t=%0t)", $time);
      end
    end
  endtask

  task automatic go(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    ctl   = c;
    d1    = a;
    d2    = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Starts at the falling edge right after the accept edge; counts falling
  // edges until done is seen (expected W), and how many of them had busy.
  task automatic wait_done(input int limit, output int n, output int nbusy);
    n     = 0;
    nbusy = 0;
    while (!done && n < limit) begin
      if (busy) nbusy++;
      @(negedge clk);
      n++;
    end
    check("done_timeout", {63'd0, done}, 64'd1);
  endtask

  int n, nb, t1, t2, dcnt;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    d1    = '0;
    d2    = '0;
    ctl   = 4'h0;
    fork
      forever begin
        @(negedge clk);
        cycle_check();
      end
    join_none
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_lo",   {32'd0, lo},   64'd0);
    check("reset_hi",   {32'd0, hi},   64'd0);
    check("reset_zero", {63'd0, zero}, 64'd1);
    check("reset_dbz",  {63'd0, dbz},  64'd0);

    // 3 * 5
    go(4'hF, 32'd3, 32'd5);
    wait_done(40, n, nb);
    check("mult_latency", 64'(n),  64'd32);
    check("mult_busy_cycles", 64'(nb), 64'd32);
    check("mult_3x5_lo", {32'd0, lo}, 64'd15);
    check("mult_3x5_hi", {32'd0, hi}, 64'd0);
    check("mult_3x5_zero", {63'd0, zero}, 64'd0);

    // max * max
    go(4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(40, n, nb);
    check("mult_max_lo", {32'd0, lo}, 64'h0000_0001);
    check("mult_max_hi", {32'd0, hi}, 64'hFFFF_FFFE);

    // 17 / 5, then 5 / 0
    go(4'hE, 32'd17, 32'd5);
    wait_done(40, n, nb);
    check("div_17_5_lo", {32'd0, lo}, 64'd3);
    check("div_17_5_hi", {32'd0, hi}, 64'd2);
    check("div_17_5_dbz", {63'd0, dbz}, 64'd0);
    go(4'hE, 32'd5, 32'd0);
    wait_done(40, n, nb);
    check("div_by0_latency", 64'(n), 64'd32);
    check("div_by0_lo", {32'd0, lo}, 64'hFFFF_FFFF);
    check("div_by0_hi", {32'd0, hi}, 64'd5);
    check("div_by0_dbz", {63'd0, dbz}, 64'd1);

    // 0 * 7, then 5 / 5
    go(4'hF, 32'd0, 32'd7);
    wait_done(40, n, nb);
    check("mult_0x7_lo", {32'd0, lo}, 64'd0);
    check("mult_0x7_zero", {63'd0, zero}, 64'd1);
    check("mult_dbz_clear", {63'd0, dbz}, 64'd0);
    go(4'hE, 32'd5, 32'd5);
    wait_done(40, n, nb);
    check("div_5_5_lo", {32'd0, lo}, 64'd1);
    check("div_5_5_hi", {32'd0, hi}, 64'd0);
    check("div_5_5_zero", {63'd0, zero}, 64'd0);

    // unsupported code is ignored
    @(negedge clk);
    ctl   = 4'b0010;
    d1    = 32'd9;
    d2    = 32'd9;
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    check("badcode_busy", {63'd0, busy}, 64'd0);
    check("badcode_lo", {32'd0, lo}, 64'd1);

    // start held with new div request and operands changed during RUN
    go(4'hF, 32'd6, 32'd7);
    start = 1'b1;
    ctl   = 4'hE;
    d1    = 32'd100;
    d2    = 32'd3;
    repeat (28) @(negedge clk);
    start = 1'b0;
    wait_done(10, n, nb);
    check("ignore_start_lo", {32'd0, lo}, 64'd42);
    check("ignore_start_hi", {32'd0, hi}, 64'd0);
    check("ignore_start_dbz", {63'd0, dbz}, 64'd0);

    // reset in the middle of an operation
    go(4'hF, 32'd3, 32'd5);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_lo", {32'd0, lo}, 64'd0);
    check("abort_hi", {32'd0, hi}, 64'd0);
    check("abort_zero", {63'd0, zero}, 64'd1);
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("abort_no_done", 64'(dcnt), 64'd0);

    // back-to-back with start held high
    @(negedge clk);
    ctl   = 4'hF;
    d1    = 32'd2;
    d2    = 32'd3;
    start = 1'b1;
    @(negedge clk);
    wait_done(40, n, nb);
    t1 = cyc;
    @(negedge clk);
    wait_done(40, n, nb);
    t2 = cyc;
    start = 1'b0;
    check("b2b_spacing", 64'(t2 - t1), 64'd34);
    check("b2b_lo", {32'd0, lo}, 64'd6);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
